// File: rtl/kb_send.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits, parity, stop, ACK.
// Optional transfer watchdog enabled by defining KB_SEND_TIMEOUT_EN.
module kb_send #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kb_clk_i,
  input  logic       kb_dat_i,
  output logic       kb_clk_oe_o,
  output logic       kb_dat_oe_o,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, ACK, RELEASE} state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  state_t           state_reg;
  logic [2:0]       clk_sync_reg;
  logic [1:0]       dat_sync_reg;
  logic [INH_W-1:0] inh_cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [7:0]       data_reg;
  logic             parity_reg;
  logic             kb_fall;
  logic             timeout;

  // [0],[1] form the synchronizer; [2] holds the previous synchronized sample
  assign kb_fall = (clk_sync_reg[2:1] == 2'b10);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk_sync_reg <= 3'b111;
      dat_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg <= {clk_sync_reg[1:0], kb_clk_i};
      dat_sync_reg <= {dat_sync_reg[0], kb_dat_i};
    end
  end

`ifdef KB_SEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;

  // Counts cycles spent outside IDLE; fires on the last allowed cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign timeout = (state_reg != IDLE) && (int'(to_cnt_reg) == TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= IDLE;
      kb_clk_oe_o <= 1'b0;
      kb_dat_oe_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      inh_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      parity_reg  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (timeout) begin
        state_reg   <= IDLE;
        kb_clk_oe_o <= 1'b0;
        kb_dat_oe_o <= 1'b0;
        busy_o      <= 1'b0;
        err_o       <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            kb_clk_oe_o <= 1'b0;
            kb_dat_oe_o <= 1'b0;
            if (start_i) begin
              data_reg    <= data_i;
              parity_reg  <= ~^data_i;
              busy_o      <= 1'b1;
              kb_clk_oe_o <= 1'b1;
              kb_dat_oe_o <= (INHIBIT_CYCLES == 1);
              inh_cnt_reg <= '0;
              state_reg   <= INHIBIT;
            end
          end
          INHIBIT: begin
            inh_cnt_reg <= inh_cnt_reg + 1'b1;
            // Data goes low one cycle before the clock is released
            if (int'(inh_cnt_reg) == INHIBIT_CYCLES - 2) begin
              kb_dat_oe_o <= 1'b1;
            end
            if (int'(inh_cnt_reg) == INHIBIT_CYCLES - 1) begin
              kb_clk_oe_o <= 1'b0;
              kb_dat_oe_o <= 1'b1;
              bit_cnt_reg <= '0;
              state_reg   <= RTS;
            end
          end
          RTS: begin
            state_reg <= XFER;
          end
          XFER: begin
            if (kb_fall) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg < 4'd8) begin
                kb_dat_oe_o <= ~data_reg[bit_cnt_reg[2:0]];
              end else if (bit_cnt_reg == 4'd8) begin
                kb_dat_oe_o <= ~parity_reg;
              end else begin
                kb_dat_oe_o <= 1'b0;
                state_reg   <= ACK;
              end
            end
          end
          ACK: begin
            if (kb_fall) begin
              if (!dat_sync_reg[1]) begin
                state_reg <= RELEASE;
              end else begin
                err_o     <= 1'b1;
                busy_o    <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end
          RELEASE: begin
            if (clk_sync_reg[1] && dat_sync_reg[1]) begin
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kb_send.sv
// Directed bench for kb_send with an open-drain PS/2 device model.
// Silent-device step checks the timeout when built with KB_SEND_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_kb_send;
  localparam int INH = 20;
  localparam int TO  = 2000;
  localparam int H   = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       kb_clk_i, kb_dat_i;
  logic       kb_clk_oe_o, kb_dat_oe_o;
  logic       start_i;
  logic [7:0] data_i;
  logic       busy_o, done_o, err_o;
  logic       dev_clk, dev_dat;

  int   cmp_cnt = 0;
  int   mis_cnt = 0;
  int   done_seen, err_seen, both_seen;
  logic busy_at_pulse, busy_after, prev_pulse;
  int   len, dat_hi, n;
  logic [9:0] bits;

  kb_send #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kb_clk_i(kb_clk_i), .kb_dat_i(kb_dat_i),
    .kb_clk_oe_o(kb_clk_oe_o), .kb_dat_oe_o(kb_dat_oe_o), .start_i(start_i),
    .data_i(data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Wired-AND open-drain lines
  assign kb_clk_i = dev_clk & ~kb_clk_oe_o;
  assign kb_dat_i = dev_dat & ~kb_dat_oe_o;

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
    if (done_o) done_seen++;
    if (err_o) err_seen++;
    if (done_o && err_o) both_seen++;
    if (prev_pulse) busy_after = busy_o;
    if (done_o || err_o) busy_at_pulse = busy_o;
    prev_pulse = done_o | err_o;
  endtask

  task automatic clear_stats();
    done_seen = 0; err_seen = 0; both_seen = 0;
    busy_at_pulse = 1'b1; busy_after = 1'b1; prev_pulse = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] d);
    data_i  = d;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    data_i  = 8'hFF;
  endtask

  // Counts cycles with kb_clk held low and how many of them also hold data low
  task automatic measure_inh(output int l, output int dh);
    l = 0; dh = 0;
    while (kb_clk_oe_o && l < 1000) begin
      l++;
      if (kb_dat_oe_o) dh++;
      tick();
    end
  endtask

  task automatic device(input int edges, input bit ack, input bit poke, output logic [9:0] b);
    b = '0;
    repeat (H) tick();
    for (int k = 1; k <= edges; k++) begin
      if (k == 11) dev_dat = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (H) tick();
      if (poke && k == 3) begin
        start_i = 1'b1; data_i = 8'hFF; tick(); start_i = 1'b0;
      end
      dev_clk = 1'b1;
      if (k <= 10) b[k-1] = kb_dat_i;
      repeat (H) tick();
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; data_i = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
    clear_stats();
    repeat (3) tick();
    check("reset_outputs", {kb_clk_oe_o, kb_dat_oe_o, busy_o, done_o, err_o}, 5'b0);
    rst_i = 1'b1;
    repeat (3) tick();

    dev_clk = 1'b0; repeat (4) tick(); dev_clk = 1'b1; repeat (4) tick();
    check("idle_edge_ignored", {kb_clk_oe_o, kb_dat_oe_o, busy_o, done_seen[0], err_seen[0]}, 5'b0);

    // 0xED with a start request injected mid-transfer
    clear_stats();
    start_xfer(8'hED);
    check("ed_busy", busy_o, 1);
    measure_inh(len, dat_hi);
    check("ed_inhibit_len", len, INH);
    check("ed_inh_dat_last", dat_hi, 1);
    check("ed_rts", {kb_clk_oe_o, kb_dat_oe_o}, 2'b01);
    device(11, 1'b1, 1'b1, bits);
    check("ed_bits", bits, 10'h3ED);
    repeat (20) tick();
    check("ed_done_cnt", done_seen, 1);
    check("ed_err_cnt", err_seen, 0);
    check("ed_both", both_seen, 0);
    check("ed_busy_at_done", busy_at_pulse, 0);
    check("ed_idle_after", {kb_clk_oe_o, kb_dat_oe_o, busy_o}, 3'b0);

    // 0xF4: odd parity bit is 0
    clear_stats();
    start_xfer(8'hF4);
    measure_inh(len, dat_hi);
    check("f4_inhibit_len", len, INH);
    device(11, 1'b1, 1'b0, bits);
    check("f4_parity", bits[8], 0);
    check("f4_bits", bits, 10'h2F4);
    repeat (20) tick();
    check("f4_done_cnt", done_seen, 1);

    // 0x3C with device refusing to ACK
    clear_stats();
    start_xfer(8'h3C);
    measure_inh(len, dat_hi);
    device(11, 1'b0, 1'b0, bits);
    repeat (20) tick();
    check("nack_bits", bits, 10'h33C);
    check("nack_err_cnt", err_seen, 1);
    check("nack_done_cnt", done_seen, 0);
    check("nack_busy_pulse", busy_at_pulse, 0);
    check("nack_busy_next", busy_after, 0);

    // 0xA5 aborted by reset after the 4th edge
    clear_stats();
    start_xfer(8'hA5);
    measure_inh(len, dat_hi);
    device(4, 1'b1, 1'b0, bits);
    check("a5_first_bits", bits[3:0], 4'h5);
    check("pre_rst_dat_oe", kb_dat_oe_o, 1);
    rst_i = 1'b0;
    #1;
    check("rst_async", {kb_clk_oe_o, kb_dat_oe_o, busy_o, done_o, err_o}, 5'b0);
    tick(); tick();
    rst_i = 1'b1;
    repeat (10) tick();
    check("rst_no_pulse", {done_seen[0], err_seen[0], busy_o}, 3'b0);

    // 0x00 after reset: parity 1
    clear_stats();
    start_xfer(8'h00);
    measure_inh(len, dat_hi);
    check("z_inhibit_len", len, INH);
    device(11, 1'b1, 1'b0, bits);
    check("z_bits", bits, 10'h300);
    repeat (20) tick();
    check("z_done_cnt", done_seen, 1);

    // Silent device
    clear_stats();
    start_xfer(8'h55);
    n = 0;
    while (!err_o && n < TO + 200) begin
      tick();
      n++;
    end
`ifdef KB_SEND_TIMEOUT_EN
    check("to_cycles", n, TO);
    check("to_lines", {kb_clk_oe_o, kb_dat_oe_o, busy_o}, 3'b0);
    check("to_err_cnt", err_seen, 1);
`else
    check("silent_busy", busy_o, 1);
    check("silent_err_cnt", err_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule

// File: doc/kb_send.md
KB_SEND -- requirements
Module: kb_send

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000; clk_i cycles kb_clk is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000; maximum clk_i cycles per transfer (15 ms at 50 MHz).
REQ-003 Port clk_i, input, 1: system clock; all logic on its rising edge.
REQ-004 Port rst_i, input, 1: reset, asynchronous, active-low.
REQ-005 Port kb_clk_i, input, 1: PS/2 clock line as sampled from the pad; asynchronous to clk_i.
REQ-006 Port kb_dat_i, input, 1: PS/2 data line as sampled from the pad; asynchronous to clk_i.
REQ-007 Port kb_clk_oe_o, output, 1: 1 = pull PS/2 clock low, 0 = release (open-drain).
REQ-008 Port kb_dat_oe_o, output, 1: 1 = pull PS/2 data low, 0 = release (open-drain).
REQ-009 Port start_i, input, 1: single-cycle request to send data_i.
REQ-010 Port data_i, input, 8: command byte; captured on the accepted start_i cycle.
REQ-011 Port busy_o, output, 1: high from the cycle after accepted start_i until done_o/err_o.
REQ-012 Port done_o, output, 1: one-cycle pulse, byte sent and acknowledged.
REQ-013 Port err_o, output, 1: one-cycle pulse, transfer failed (no ACK or timeout).

Function
REQ-014 kb_clk_i and kb_dat_i SHALL each pass a 2-flop synchronizer; a falling edge is synchronized history 2'b10.
REQ-015 States: IDLE, INHIBIT, RTS, XFER, ACK, RELEASE.
REQ-016 IDLE: both oe low; start_i accepted only in IDLE; data_i latched; odd parity (~^data_i) latched; next INHIBIT.
REQ-017 INHIBIT: kb_clk_oe_o=1 for exactly INHIBIT_CYCLES cycles; kb_dat_oe_o asserted in the last INHIBIT cycle; falling edges ignored; next RTS.
REQ-018 RTS: kb_clk_oe_o=0, kb_dat_oe_o=1 (start bit); next XFER immediately.
REQ-019 XFER: bit counter 0..9; on falling edge k (k=1..8) kb_dat_oe_o = ~data[k-1] (LSB first); edge 9 drives ~parity; edge 10 releases data (stop bit=1); next ACK.
REQ-020 ACK: on next falling edge sample synchronized kb_dat; 0 = ACK, go RELEASE; 1 = pulse err_o, go IDLE.
REQ-021 RELEASE: wait until synchronized kb_clk and kb_dat are both 1; then pulse done_o, go IDLE.
REQ-022 done_o and err_o SHALL never assert in the same cycle; busy_o deasserts in the pulse cycle.
REQ-023 start_i while busy_o=1 SHALL be ignored; data_i changes after acceptance SHALL not affect the transfer.
REQ-024 Falling edges in IDLE or RELEASE SHALL be ignored (no state change).

Reset
REQ-025 rst_i=0 SHALL immediately force state IDLE, kb_clk_oe_o=0, kb_dat_oe_o=0, busy_o=0, done_o=0, err_o=0, counters and synchronizers to released (1) values.
REQ-026 Reset mid-transfer SHALL abort without a done_o/err_o pulse; first start_i after release SHALL start a fresh transfer.

Configuration
REQ-027 Macro KB_SEND_TIMEOUT_EN defined: counter runs from leaving IDLE; reaching TIMEOUT_CYCLES in any non-IDLE state releases both lines, pulses err_o, returns IDLE.
REQ-028 KB_SEND_TIMEOUT_EN undefined: no timeout counter; err_o only from missing ACK; a silent device leaves busy_o=1 until reset.

Verification
REQ-029 start_i with 0xED, device model clocks 11 edges, ACKs -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released; done_o one pulse.
REQ-030 start_i with 0xF4 -> parity bit 0 observed on edge 9; kb_clk_oe_o low-hold measured exactly INHIBIT_CYCLES.
REQ-031 Device holds data high on ACK edge -> err_o one pulse, no done_o, busy_o=0 next cycle.
REQ-032 KB_SEND_TIMEOUT_EN, device never clocks -> err_o at TIMEOUT_CYCLES, both oe 0; without macro busy_o stays 1.
REQ-033 rst_i low after edge 4 -> both oe 0 within the reset cycle, no pulses; next start_i 0x00 sends parity 1 and completes.
REQ-034 start_i asserted during busy with 0xFF -> ignored; byte in flight unchanged.
